// File: rtl/matrix_ram_pkg.sv
// Shared types for the matrix memory controller.
//   state_e  : controller states (IDLE, LOAD, RUN)
//   RD0/RD1  : requester indices, also used as round-robin pointer values
package matrix_ram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_e;

    localparam logic RD0 = 1'b0;
    localparam logic RD1 = 1'b1;

endpackage

// File: rtl/xilinx_single_port_ram_block.sv
// Single-port block RAM, read-first, in the shape of the vendor template.
//   clka   : clock
//   addra  : word address
//   dina   : write data
//   wea    : write enable (qualified by ena)
//   ena    : port enable; a read is performed whenever ena is high
//   rsta   : output register reset (HIGH_PERFORMANCE only)
//   regcea : output register enable (HIGH_PERFORMANCE only)
//   douta  : read data, 1 cycle after ena (LOW_LATENCY) or 2 (HIGH_PERFORMANCE)
module xilinx_single_port_ram_block #(
    parameter int RAM_WIDTH       = 16,
    parameter int RAM_DEPTH       = 4096,
    parameter     RAM_PERFORMANCE = "LOW_LATENCY",
    parameter int ADDR_W          = $clog2(RAM_DEPTH)
) (
    input  logic                 clka,
    input  logic [ADDR_W-1:0]    addra,
    input  logic [RAM_WIDTH-1:0] dina,
    input  logic                 wea,
    input  logic                 ena,
    input  logic                 rsta,
    input  logic                 regcea,
    output logic [RAM_WIDTH-1:0] douta
);

    logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];
    logic [RAM_WIDTH-1:0] ram_data_q;

    // No reset on the array or its read latch so it maps onto block RAM.
    always_ff @(posedge clka) begin
        if (ena) begin
            if (wea) begin
                mem[addra] <= dina;
            end
            ram_data_q <= mem[addra];
        end
    end

    generate
        if (RAM_PERFORMANCE == "LOW_LATENCY") begin : g_low_latency
            assign douta = ram_data_q;
        end else begin : g_high_perf
            logic [RAM_WIDTH-1:0] douta_q;
            always_ff @(posedge clka) begin
                if (rsta) begin
                    douta_q <= '0;
                end else if (regcea) begin
                    douta_q <= ram_data_q;
                end
            end
            assign douta = douta_q;
        end
    endgenerate

    // rsta/regcea only matter for the registered-output variant.
    logic unused_ctrl;
    assign unused_ctrl = &{1'b0, rsta, regcea};

endmodule

// File: rtl/matrix_ram_ctrl.sv
// Matrix memory sequencer and read arbiter.
// Loads RAM_DEPTH words from a valid/ready stream into one single-port RAM,
// then shares reads round-robin between two requesters (1-cycle latency).
//
// state | meaning
// IDLE  | after reset, no matrix, no grants
// LOAD  | accepting load words in ascending address order
// RUN   | matrix valid, reads arbitrated
//
// Ports:
//   clk, rst_n                 : clock, async active-low reset
//   load_start                 : pulse, (re)starts a full load
//   ld_valid/ld_data/ld_ready  : load stream
//   busy, matrix_valid         : status, decoded from state
//   rdX_req/rdX_addr           : read request, held until granted
//   rdX_gnt                    : combinational grant
//   rdX_rvalid/rdX_rdata       : read response, one cycle after grant
module matrix_ram_ctrl
    import matrix_ram_pkg::*;
#(
    parameter int RAM_WIDTH = 16,
    parameter int RAM_DEPTH = 4096,
    parameter int ADDR_W    = $clog2(RAM_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_start,
    input  logic                 ld_valid,
    input  logic [RAM_WIDTH-1:0] ld_data,
    output logic                 ld_ready,
    output logic                 busy,
    output logic                 matrix_valid,
    input  logic                 rd0_req,
    input  logic [ADDR_W-1:0]    rd0_addr,
    output logic                 rd0_gnt,
    output logic                 rd0_rvalid,
    output logic [RAM_WIDTH-1:0] rd0_rdata,
    input  logic                 rd1_req,
    input  logic [ADDR_W-1:0]    rd1_addr,
    output logic                 rd1_gnt,
    output logic                 rd1_rvalid,
    output logic [RAM_WIDTH-1:0] rd1_rdata
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_DEPTH - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   wr_cnt_q, wr_cnt_d;
    logic                prio_q, prio_d;         // requester favoured on a tie
    logic                rvalid_q, rvalid_d;
    logic                resp_sel_q, resp_sel_d; // which reader owns douta

    logic                 ld_accept;
    logic                 gnt0;
    logic                 gnt1;
    logic                 ram_en;
    logic [ADDR_W-1:0]    ram_addr;
    logic [RAM_WIDTH-1:0] ram_dout;

    always_comb begin
        state_d    = state_q;
        wr_cnt_d   = wr_cnt_q;
        prio_d     = prio_q;
        ld_accept  = 1'b0;
        gnt0       = 1'b0;
        gnt1       = 1'b0;

        case (state_q)
            LOAD: begin
                // A restart in the same cycle discards the presented word.
                ld_accept = ld_valid && !load_start;
                if (ld_accept) begin
                    wr_cnt_d = wr_cnt_q + ADDR_W'(1);
                    if (wr_cnt_q == LAST_ADDR) begin
                        state_d  = RUN;
                        wr_cnt_d = '0;
                    end
                end
            end
            RUN: begin
                gnt0 = rd0_req && (!rd1_req || prio_q == RD0);
                gnt1 = rd1_req && (!rd0_req || prio_q == RD1);
                if (gnt0) prio_d = RD1;
                if (gnt1) prio_d = RD0;
            end
            default: ;
        endcase

        // Grants issued this cycle still complete; the first reload write
        // lands one cycle later, so the response sees the old contents.
        if (load_start) begin
            state_d  = LOAD;
            wr_cnt_d = '0;
        end

        rvalid_d   = gnt0 || gnt1;
        resp_sel_d = gnt1 ? RD1 : (gnt0 ? RD0 : resp_sel_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wr_cnt_q   <= '0;
            prio_q     <= RD0;
            rvalid_q   <= 1'b0;
            resp_sel_q <= RD0;
        end else begin
            state_q    <= state_d;
            wr_cnt_q   <= wr_cnt_d;
            prio_q     <= prio_d;
            rvalid_q   <= rvalid_d;
            resp_sel_q <= resp_sel_d;
        end
    end

    // Writes happen only in LOAD and grants only in RUN, so the single
    // port is never contended.
    assign ram_en   = ld_accept || gnt0 || gnt1;
    assign ram_addr = ld_accept ? wr_cnt_q : (gnt1 ? rd1_addr : rd0_addr);

    xilinx_single_port_ram_block #(
        .RAM_WIDTH      (RAM_WIDTH),
        .RAM_DEPTH      (RAM_DEPTH),
        .RAM_PERFORMANCE("LOW_LATENCY"),
        .ADDR_W         (ADDR_W)
    ) u_ram (
        .clka  (clk),
        .addra (ram_addr),
        .dina  (ld_data),
        .wea   (ld_accept),
        .ena   (ram_en),
        .rsta  (1'b0),
        .regcea(1'b1),
        .douta (ram_dout)
    );

    assign ld_ready     = (state_q == LOAD);
    assign busy         = (state_q == LOAD);
    assign matrix_valid = (state_q == RUN);

    assign rd0_gnt = gnt0;
    assign rd1_gnt = gnt1;

    // The RAM output latch has no reset; gating with rvalid keeps rdata at 0
    // through reset and between responses.
    assign rd0_rvalid = rvalid_q && (resp_sel_q == RD0);
    assign rd1_rvalid = rvalid_q && (resp_sel_q == RD1);
    assign rd0_rdata  = rd0_rvalid ? ram_dout : '0;
    assign rd1_rdata  = rd1_rvalid ? ram_dout : '0;

endmodule

// File: tb/tb_matrix_ram_ctrl.sv
// Directed bench for matrix_ram_ctrl: reset values, full loads (with and
// without stalls), single and contended reads, reload from RUN, reset mid-load.
module tb_matrix_ram_ctrl;

    localparam int W  = 16;
    localparam int D  = 4096;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load_start = 1'b0;
    logic          ld_valid = 1'b0;
    logic [W-1:0]  ld_data = '0;
    logic          ld_ready;
    logic          busy;
    logic          matrix_valid;
    logic          rd0_req = 1'b0;
    logic [AW-1:0] rd0_addr = '0;
    logic          rd0_gnt;
    logic          rd0_rvalid;
    logic [W-1:0]  rd0_rdata;
    logic          rd1_req = 1'b0;
    logic [AW-1:0] rd1_addr = '0;
    logic          rd1_gnt;
    logic          rd1_rvalid;
    logic [W-1:0]  rd1_rdata;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    matrix_ram_ctrl #(.RAM_WIDTH(W), .RAM_DEPTH(D)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_start  (load_start),
        .ld_valid    (ld_valid),
        .ld_data     (ld_data),
        .ld_ready    (ld_ready),
        .busy        (busy),
        .matrix_valid(matrix_valid),
        .rd0_req     (rd0_req),
        .rd0_addr    (rd0_addr),
        .rd0_gnt     (rd0_gnt),
        .rd0_rvalid  (rd0_rvalid),
        .rd0_rdata   (rd0_rdata),
        .rd1_req     (rd1_req),
        .rd1_addr    (rd1_addr),
        .rd1_gnt     (rd1_gnt),
        .rd1_rvalid  (rd1_rvalid),
        .rd1_rdata   (rd1_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Load data patterns: 0 = address, 1 = address ^ A5A5, 2 = ~address.
    function automatic logic [W-1:0] pat_val(input int pat, input int i);
        logic [W-1:0] a;
        a = W'(i);
        case (pat)
            1:       return a ^ 16'hA5A5;
            2:       return ~a;
            default: return a;
        endcase
    endfunction

    task automatic do_load(input int pat, input bit toggle, input bit send_start, input int n_words);
        int busy_cyc;
        int bad;
        busy_cyc = 0;
        bad = 0;
        if (send_start) begin
            load_start = 1'b1;
            ld_valid   = 1'b0;
            step();
            load_start = 1'b0;
        end
        chk("load_ready", 32'(ld_ready), 32'd1);
        chk("load_busy", 32'(busy), 32'd1);
        chk("load_mv_low", 32'(matrix_valid), 32'd0);
        for (int i = 0; i < n_words; i++) begin
            if (toggle && (i % 2 == 1)) begin
                ld_valid = 1'b0;
                ld_data  = 16'hDEAD;
                #1;
                if (rd0_gnt || rd1_gnt) bad++;
                if (busy) busy_cyc++;
                step();
                if (!busy || matrix_valid) bad++;
            end
            ld_valid = 1'b1;
            ld_data  = pat_val(pat, i);
            #1;
            if (rd0_gnt || rd1_gnt || !ld_ready) bad++;
            if (busy) busy_cyc++;
            step();
            if (i < D - 1 && (!busy || matrix_valid)) bad++;
        end
        ld_valid = 1'b0;
        chk("load_no_gnt_no_early_exit", 32'(bad), 32'd0);
        if (n_words == D) begin
            chk("load_busy_cycles", 32'(busy_cyc), toggle ? 32'd6144 : 32'd4096);
            chk("load_exit_mv", 32'(matrix_valid), 32'd1);
            chk("load_exit_busy", 32'(busy), 32'd0);
            chk("load_exit_ready", 32'(ld_ready), 32'd0);
        end
    endtask

    task automatic rd_check(input int port, input logic [AW-1:0] addr, input logic [W-1:0] exp);
        rd0_req = (port == 0);
        rd1_req = (port == 1);
        if (port == 0) rd0_addr = addr; else rd1_addr = addr;
        #1;
        chk("single_gnt0", 32'(rd0_gnt), (port == 0) ? 32'd1 : 32'd0);
        chk("single_gnt1", 32'(rd1_gnt), (port == 1) ? 32'd1 : 32'd0);
        step();
        rd0_req = 1'b0;
        rd1_req = 1'b0;
        chk("single_rvalid0", 32'(rd0_rvalid), (port == 0) ? 32'd1 : 32'd0);
        chk("single_rvalid1", 32'(rd1_rvalid), (port == 1) ? 32'd1 : 32'd0);
        chk("single_rdata", 32'((port == 0) ? rd0_rdata : rd1_rdata), 32'(exp));
    endtask

    initial begin
        logic [AW-1:0] a0;
        logic [AW-1:0] a1;
        bit            exp1;

        // Reset held with requests and load traffic present.
        rd0_req  = 1'b1;
        rd1_req  = 1'b1;
        ld_valid = 1'b1;
        repeat (3) step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(ld_ready), 32'd0);
        chk("rst_mv", 32'(matrix_valid), 32'd0);
        chk("rst_gnt0", 32'(rd0_gnt), 32'd0);
        chk("rst_gnt1", 32'(rd1_gnt), 32'd0);
        chk("rst_rvalid0", 32'(rd0_rvalid), 32'd0);
        chk("rst_rvalid1", 32'(rd1_rvalid), 32'd0);
        chk("rst_rdata0", 32'(rd0_rdata), 32'd0);
        chk("rst_rdata1", 32'(rd1_rdata), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("idle_gnt0", 32'(rd0_gnt), 32'd0);
        chk("idle_gnt1", 32'(rd1_gnt), 32'd0);
        step();
        chk("idle_ready", 32'(ld_ready), 32'd0);
        chk("idle_rvalid0", 32'(rd0_rvalid), 32'd0);
        rd0_req  = 1'b0;
        rd1_req  = 1'b0;
        ld_valid = 1'b0;

        // Full load, data = address.
        do_load(0, 1'b0, 1'b1, D);

        // Single reader.
        rd_check(0, 12'h123, 16'h0123);

        // Contention: rd0 was granted last, so rd1 wins first.
        a0 = 12'h010;
        a1 = 12'h800;
        for (int k = 0; k < 6; k++) begin
            rd0_req  = 1'b1;
            rd1_req  = 1'b1;
            rd0_addr = a0;
            rd1_addr = a1;
            exp1 = (k % 2 == 0);
            #1;
            chk("rr_gnt0", 32'(rd0_gnt), exp1 ? 32'd0 : 32'd1);
            chk("rr_gnt1", 32'(rd1_gnt), exp1 ? 32'd1 : 32'd0);
            step();
            chk("rr_rvalid0", 32'(rd0_rvalid), exp1 ? 32'd0 : 32'd1);
            chk("rr_rvalid1", 32'(rd1_rvalid), exp1 ? 32'd1 : 32'd0);
            if (exp1) begin
                chk("rr_rdata1", 32'(rd1_rdata), 32'(16'h0800 + 16'(k / 2)));
                a1 = a1 + 12'd1;
            end else begin
                chk("rr_rdata0", 32'(rd0_rdata), 32'(16'h0010 + 16'(k / 2)));
                a0 = a0 + 12'd1;
            end
        end
        rd0_req = 1'b0;
        rd1_req = 1'b0;

        // Reload from RUN with 50% stalls, data = address ^ A5A5.
        do_load(1, 1'b1, 1'b1, D);
        rd_check(0, 12'h000, 16'hA5A5);
        rd_check(1, 12'hABC, 16'hAF19);
        rd_check(0, 12'hFFF, 16'hAA5A);

        // load_start in the same cycle rd1 is granted.
        rd1_req    = 1'b1;
        rd1_addr   = 12'h456;
        load_start = 1'b1;
        #1;
        chk("restart_gnt1", 32'(rd1_gnt), 32'd1);
        step();
        load_start = 1'b0;
        rd1_addr   = 12'h457;
        chk("restart_rvalid1", 32'(rd1_rvalid), 32'd1);
        chk("restart_old_data", 32'(rd1_rdata), 32'h0000A1F3);
        chk("restart_mv_low", 32'(matrix_valid), 32'd0);
        do_load(2, 1'b0, 1'b0, D);
        #1;
        chk("reload_gnt1", 32'(rd1_gnt), 32'd1);
        step();
        rd1_req = 1'b0;
        chk("reload_rdata1", 32'(rd1_rdata), 32'h0000FBA8);

        // Reset after 100 load words.
        do_load(0, 1'b0, 1'b1, 100);
        rd0_req  = 1'b1;
        rd0_addr = 12'h005;
        rst_n    = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_ready", 32'(ld_ready), 32'd0);
        chk("midrst_mv", 32'(matrix_valid), 32'd0);
        chk("midrst_gnt0", 32'(rd0_gnt), 32'd0);
        chk("midrst_rvalid0", 32'(rd0_rvalid), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        #1;
        chk("postrst_gnt0", 32'(rd0_gnt), 32'd0);
        step();
        chk("postrst_mv", 32'(matrix_valid), 32'd0);
        chk("postrst_rvalid0", 32'(rd0_rvalid), 32'd0);
        rd0_req = 1'b0;
        do_load(0, 1'b0, 1'b1, D);

        // Pointer came out of reset favouring rd0.
        rd0_req  = 1'b1;
        rd1_req  = 1'b1;
        rd0_addr = 12'd100;
        rd1_addr = 12'd200;
        #1;
        chk("ptr_rst_gnt0", 32'(rd0_gnt), 32'd1);
        chk("ptr_rst_gnt1", 32'(rd1_gnt), 32'd0);
        step();
        chk("ptr_rst_rdata0", 32'(rd0_rdata), 32'd100);
        #1;
        chk("ptr_next_gnt1", 32'(rd1_gnt), 32'd1);
        step();
        rd0_req = 1'b0;
        rd1_req = 1'b0;
        chk("ptr_next_rdata1", 32'(rd1_rdata), 32'd200);
        rd_check(1, 12'hFFF, 16'h0FFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/matrix_ram_ctrl.md
# matrix_ram_ctrl

Sequencer and arbiter for the miner's matrix memory. It loads a full matrix into one single-port block RAM from a valid/ready stream, then shares read access round-robin between two hash-datapath requesters. Reads are one request per cycle, with data returned after a fixed latency of one cycle. It sits between the host-side matrix loader and the two hash cores.

## Interface
Parameters:
- RAM_WIDTH, 16: matrix word width in bits.
- RAM_DEPTH, 4096: number of matrix words; must be ≥ 2.
- ADDR_W, $clog2(RAM_DEPTH): address width (derived, do not override).

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  sole clock.
- rst_n  in  1  asynchronous active-low reset.
- load_start  in  1  single-cycle pulse; (re)starts a full matrix load.
- ld_valid  in  1  load word valid.
- ld_data  in  RAM_WIDTH  load word, written in ascending address order.
- ld_ready  out  1  load word accepted when ld_valid && ld_ready.
- busy  out  1  high while in LOAD.
- matrix_valid  out  1  full matrix present; reads are serviced.
- rd0_req, rd1_req  in  1  read request; held until granted.
- rd0_addr, rd1_addr  in  ADDR_W  read address; held with req.
- rd0_gnt, rd1_gnt  out  1  request accepted this cycle.
- rd0_rvalid, rd1_rvalid  out  1  read data valid pulse.
- rd0_rdata, rd1_rdata  out  RAM_WIDTH  read data; meaningful only with the matching rvalid.

## Operation
- FSM states: IDLE, LOAD, RUN.
  - IDLE is the reset state.
  - load_start in any state → LOAD. It clears the write counter to 0 and drops matrix_valid to 0.
- LOAD:
  - ld_ready = 1.
  - Each accepted word writes RAM[wr_cnt] and increments wr_cnt.
  - The accept at wr_cnt == RAM_DEPTH-1 → RUN and sets matrix_valid = 1 on the following cycle.
  - ld_valid low stalls the load with no timeout.
  - load_start during LOAD restarts at address 0; that cycle's ld word is not accepted.
- RUN:
  - ld_ready = 0.
  - Readers are arbitrated, with at most one grant per cycle.
  - If only one reader requests, it is granted.
  - If both request, the reader not granted most recently wins. The round-robin pointer resets to favour rd0.
  - The pointer updates only on a grant.
- No grants are issued in IDLE or LOAD. Requests simply wait.
- Read responses:
  - A grant in cycle N produces rdX_rvalid = 1 with rdX_rdata = RAM[addr] in cycle N+1.
  - A response issued in the cycle a load_start arrives is still delivered in the next cycle.
  - Its data is the old contents, because the load's first write happens no earlier than that cycle + 1.
- wr_cnt is ADDR_W bits wide. It never wraps in normal operation because the LOAD exit happens at RAM_DEPTH-1.

## Timing
- Values held while rst_n is low: state = IDLE, wr_cnt = 0, rr pointer → rd0, matrix_valid = 0, busy = 0, ld_ready = 0, both gnt = 0, both rvalid = 0, both rdata = 0.
- ld_ready, busy and matrix_valid are decoded from registered state only, with no combinational path from inputs.
- rdX_gnt is combinational from rdX_req, the state and the rr pointer, so it is valid in the same cycle as the request.
- Read latency is exactly 1 cycle from grant to rvalid. Throughput is one read per cycle in aggregate.
- Load throughput is one word per cycle. The minimum LOAD duration is RAM_DEPTH cycles.
- Reset mid-load: the matrix is not valid afterwards, and a new load_start is required. RAM contents are undefined from the reader's point of view.
- A write and a read are never issued in the same cycle, because the RAM is single-port.

## Structure
- Package matrix_ram_pkg holds:
  - the state enum typedef (IDLE, LOAD, RUN);
  - the requester-index localparams (RD0 = 0, RD1 = 1).
- Sub-module: instantiate xilinx_single_port_ram_block with RAM_PERFORMANCE = "LOW_LATENCY" and rsta/regcea tied off.
  - ena is asserted on any write or grant.
  - wea is asserted only on a LOAD accept.
- A one-bit registered "last responder" tag steers ram douta to rd0_rdata or rd1_rdata.

## Test plan
- Reset, then load_start, then 4096 words with ld_data = address → busy is high for ≥4096 cycles, and matrix_valid rises the cycle after the last accept.
- Loaded matrix, rd0_req with addr = 0x123 alone → rd0_gnt in the same cycle, then rd0_rvalid with rdata = 0x0123 one cycle later. rd1_rvalid stays 0.
- Both readers request continuously with different addresses → grants alternate rd0, rd1, rd0, ..., and each rvalid follows its grant by 1 cycle with the correct data.
- Load with ld_valid toggling 50% → RAM contents are exact, and the LOAD exit happens only after 4096 accepts.
- load_start in RUN while rd1 is granted → rd1 still receives old data next cycle, then matrix_valid = 0 and no further grants until the reload completes.
- rst_n asserted mid-load at word 100 → every output returns to its reset value immediately, and there are no grants until a fresh load completes.
